pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum MEM_WAIT cycles before forced release.
REQ-002 SHALL have parameter CNT_W, default 16: width of stall_cnt.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports id_rs1, id_rs2  in  5 each  source register fields of the instruction in IF/ID.
REQ-006 SHALL have ports ex_rd (in, 5) and ex_memread (in, 1): destination register and load flag of the instruction in ID/EX.
REQ-007 SHALL have port mem_branch_taken  in  1  taken branch or jump resolved in EX/MEM.
REQ-008 SHALL have ports dmem_req (in, 1) and dmem_ready (in, 1): data-memory access pending in MEM, and completion.
REQ-009 SHALL have outputs pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each: pipeline register enables.
REQ-010 SHALL have outputs if_id_hazard, id_ex_bubble, ex_mem_bubble, mem_wb_bubble  out  1 each: each makes the target register load all-zero control.
REQ-011 SHALL have output pc_sel_target  out  1: PC loads the EX/MEM branch target.
REQ-012 SHALL have outputs state (out, 1: 0=RUN, 1=MEM_WAIT), stall_cnt (out, CNT_W) and timeout_err (out, 1).

Function
REQ-013 SHALL define load_use = ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-014 SHALL define mem_stall = dmem_req & ~dmem_ready.
REQ-015 SHALL, in RUN with no event, drive all enables 1, all bubbles 0, pc_sel_target 0.
REQ-016 SHALL apply event priority mem_stall > mem_branch_taken > load_use.
REQ-017 SHALL, in RUN on mem_stall, in the same cycle:
- drive pc_en, if_id_en, id_ex_en, ex_mem_en to 0.
- drive mem_wb_en 1 and mem_wb_bubble 1.
- move to MEM_WAIT next edge and load wait_cnt with 1.
REQ-018 SHALL, in RUN on mem_branch_taken without mem_stall, in the same cycle:
- drive all enables 1.
- drive pc_sel_target, if_id_hazard, id_ex_bubble, ex_mem_bubble to 1.
- stay in RUN.
REQ-019 SHALL, in RUN on load_use alone, in the same cycle:
- drive pc_en 0 and if_id_en 0.
- drive id_ex_bubble 1; all other enables 1.
- stay in RUN; with no new event, the following cycle is a normal RUN cycle.
REQ-020 SHALL, in MEM_WAIT while dmem_ready=0 and wait_cnt < MEM_TIMEOUT, repeat the REQ-017 outputs and increment wait_cnt.
REQ-021 SHALL, in MEM_WAIT with dmem_ready=1, in the same cycle:
- behave as a RUN cycle without the mem_stall term, so a pending branch or load_use is served.
- return to RUN next edge.
REQ-022 SHALL, in MEM_WAIT with dmem_ready=0 and wait_cnt == MEM_TIMEOUT, release exactly as REQ-021, set timeout_err (sticky until reset) and return to RUN.
REQ-023 SHALL increment stall_cnt on each edge where pc_en=0 while not in reset, saturating at all-ones with no wrap.
REQ-024 SHALL ignore mem_branch_taken and load_use inside MEM_WAIT until the release cycle.

Reset
REQ-025 SHALL, while arst=1, force state RUN, wait_cnt 0, stall_cnt 0, timeout_err 0.
REQ-026 SHALL, while arst=1, drive all enables, all bubbles and pc_sel_target to 0.
REQ-027 SHALL, if arst asserts mid MEM_WAIT, abandon the wait immediately; the first cycle after release is RUN.

Verification
REQ-028 SHALL cover load-use: ex_memread=1, ex_rd=5, id_rs2=5 for one cycle -> pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cnt 0->1; next cycle all enables 1.
REQ-029 SHALL cover x0 exclusion: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall, all enables 1.
REQ-030 SHALL cover a branch colliding with load_use: mem_branch_taken=1 plus load_use -> pc_sel_target=1, if_id_hazard=1, id_ex_bubble=1, ex_mem_bubble=1, pc_en=1.
REQ-031 SHALL cover a 3-cycle memory wait: dmem_req=1, dmem_ready low for 3 cycles then high:
- state=1 for 3 cycles, with mem_wb_bubble=1 and other enables 0.
- release cycle with all enables 1, then RUN.
- stall_cnt=3.
REQ-032 SHALL cover timeout: dmem_ready held 0 with MEM_TIMEOUT=4 -> release after the 4th MEM_WAIT cycle, timeout_err=1 and held, state=0.
REQ-033 SHALL cover reset mid-wait: arst pulsed in MEM_WAIT -> outputs immediately 0 and counters cleared; after release, state=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, taken-branch flush and data-memory wait stalls.
// Combinational enables/bubbles from current state and inputs; MEM_WAIT bounded by MEM_TIMEOUT.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             mem_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_hazard,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             pc_sel_target,
  output logic             state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t          cur_state, nxt_state;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            load_use, mem_stall, timeout_hit, hold;

  assign load_use  = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign mem_stall = dmem_req && !dmem_ready;

  assign timeout_hit = (cur_state == MEM_WAIT) && !dmem_ready &&
                       (wait_cnt >= WC_W'(MEM_TIMEOUT));
  // hold: this cycle freezes the front of the pipe and drains MEM/WB with a bubble
  assign hold = (cur_state == RUN) ? mem_stall : (!dmem_ready && !timeout_hit);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cur_state   <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    wait_nxt  = wait_cnt;
    case (cur_state)
      RUN: begin
        if (mem_stall) begin
          nxt_state = MEM_WAIT;
          wait_nxt  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hold) begin
          wait_nxt = wait_cnt + WC_W'(1);
        end else begin
          nxt_state = RUN;
          wait_nxt  = '0;
        end
      end
      default: begin
        nxt_state = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_hazard  = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    pc_sel_target = 1'b0;
    if (!arst) begin
      if (hold) begin
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        if (mem_branch_taken) begin
          pc_sel_target = 1'b1;
          if_id_hazard  = 1'b1;
          id_ex_bubble  = 1'b1;
          ex_mem_bubble = 1'b1;
        end else if (load_use) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: MEM_TIMEOUT=4 and a 4-bit stall counter
// so timeout and counter saturation are reachable in a few cycles.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_hazard, id_ex/ex_mem/mem_wb bubbles, pc_sel_target}
  localparam logic [9:0] C_ZERO   = 10'b00000_0000_0;
  localparam logic [9:0] C_NORM   = 10'b11111_0000_0;
  localparam logic [9:0] C_MSTALL = 10'b00001_0001_0;
  localparam logic [9:0] C_BRANCH = 10'b11111_1110_1;
  localparam logic [9:0] C_LU     = 10'b00111_0100_0;

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic ex_memread = 1'b0, mem_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_hazard, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, pc_sel_target;
  logic state, timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [9:0] ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst(arst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_branch_taken(mem_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_hazard(if_id_hazard), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
    .pc_sel_target(pc_sel_target), .state(state), .stall_cnt(stall_cnt),
    .timeout_err(timeout_err)
  );

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_hazard, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, pc_sel_target};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_memread = mr;
    mem_branch_taken = br; dmem_req = req; dmem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    arst = 1'b1;
    tick();
    arst = 1'b0;
    #1;
  endtask

  initial begin
    // reset state
    #1 arst = 1'b1;
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(C_ZERO));
    check("rst_state", 32'(state), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    tick();
    arst = 1'b0;
    #1;

    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("normal_ctrl", 32'(ctrl), 32'(C_NORM));

    // load-use on rs2 for one cycle
    drive(5'd7, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_ctrl", 32'(ctrl), 32'(C_LU));
    check("lu_cnt_before", 32'(stall_cnt), 32'd0);
    tick();
    check("lu_cnt_after", 32'(stall_cnt), 32'd1);
    drive(5'd7, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_next_normal", 32'(ctrl), 32'(C_NORM));
    tick();

    // x0 destination never creates a hazard
    drive(5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("x0_ctrl", 32'(ctrl), 32'(C_NORM));
    tick();
    check("x0_cnt", 32'(stall_cnt), 32'd1);

    // branch beats load-use
    drive(5'd4, 5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    check("br_lu_ctrl", 32'(ctrl), 32'(C_BRANCH));
    tick();
    check("br_lu_state", 32'(state), 32'd0);

    // 3-cycle memory wait; branch+load-use held off until the release cycle
    do_reset();
    drive(5'd4, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mw_c1_ctrl", 32'(ctrl), 32'(C_MSTALL));
    check("mw_c1_state", 32'(state), 32'd0);
    tick();
    check("mw_c2_ctrl", 32'(ctrl), 32'(C_MSTALL));
    check("mw_c2_state", 32'(state), 32'd1);
    tick();
    check("mw_c3_ctrl", 32'(ctrl), 32'(C_MSTALL));
    check("mw_c3_state", 32'(state), 32'd1);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mw_rel_ctrl", 32'(ctrl), 32'(C_NORM));
    check("mw_rel_state", 32'(state), 32'd1);
    drive(5'd4, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    check("mw_rel_branch", 32'(ctrl), 32'(C_BRANCH));
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mw_after_state", 32'(state), 32'd0);
    check("mw_after_ctrl", 32'(ctrl), 32'(C_NORM));
    check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    check("mw_no_timeout", 32'(timeout_err), 32'd0);

    // timeout with MEM_TIMEOUT=4: RUN stall cycle, MEM_WAIT cycles 1..3 stall, 4th releases
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("to_run_ctrl", 32'(ctrl), 32'(C_MSTALL));
    tick();
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("to_wait%0d_ctrl", i), 32'(ctrl), 32'(C_MSTALL));
      check($sformatf("to_wait%0d_err", i), 32'(timeout_err), 32'd0);
      tick();
    end
    check("to_rel_ctrl", 32'(ctrl), 32'(C_NORM));
    check("to_rel_state", 32'(state), 32'd1);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_state", 32'(state), 32'd0);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_stall_cnt", 32'(stall_cnt), 32'd4);
    tick();
    tick();
    check("to_err_sticky", 32'(timeout_err), 32'd1);

    // reset asserted in MEM_WAIT (timeout_err still set from above)
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("rmw_in_wait", 32'(state), 32'd1);
    #2 arst = 1'b1;
    #1;
    check("rmw_ctrl", 32'(ctrl), 32'(C_ZERO));
    check("rmw_state", 32'(state), 32'd0);
    check("rmw_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rmw_err", 32'(timeout_err), 32'd0);
    tick();
    arst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rmw_after_state", 32'(state), 32'd0);
    check("rmw_after_ctrl", 32'(ctrl), 32'(C_NORM));
    tick();

    // stall counter saturates at all-ones
    do_reset();
    drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    check("sat_ctrl", 32'(ctrl), 32'(C_LU));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
